// File: rtl/tft_pkg.sv
// Shared definitions for the TFT touch-drawing front end: panel geometry,
// widths, FSM state encoding and a bounds helper.
package tft_pkg;

  localparam int unsigned TFT_X_RES   = 480;
  localparam int unsigned TFT_Y_RES   = 272;
  localparam int unsigned TFT_COORD_W = 12;
  localparam int unsigned TFT_COLOR_W = 9;
  localparam logic [TFT_COLOR_W-1:0] TFT_BG_COLOR = 9'h000;

  typedef enum logic [2:0] {IDLE, SETUP, DRAW, CLEAR, DONE} state_t;

  function automatic logic in_bounds(input int unsigned x, input int unsigned y,
                                     input int unsigned xres = TFT_X_RES,
                                     input int unsigned yres = TFT_Y_RES);
    return (x < xres) && (y < yres);
  endfunction

endpackage

// File: rtl/tft_line_stepper.sv
// Bresenham line core: load latches both end points and the step/error terms,
// each step advances one point toward (x1,y1); last flags the end point.
module tft_line_stepper #(
  parameter int unsigned COORD_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic               step,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last
);

  localparam int unsigned SW = COORD_W + 2;
  typedef logic signed [SW-1:0] scoord_t;

  scoord_t cx, cy, ex, ey, dx, dy, err, sx, sy;
  scoord_t ddx, ddy, adx, ady;
  scoord_t cx_n, cy_n, err_n;
  logic signed [SW:0] e2, dxw, dyw;

  always_comb begin
    ddx = scoord_t'({2'b00, x1}) - scoord_t'({2'b00, x0});
    ddy = scoord_t'({2'b00, y1}) - scoord_t'({2'b00, y0});
    adx = ddx[SW-1] ? -ddx : ddx;
    ady = ddy[SW-1] ? -ddy : ddy;
    e2  = {err, 1'b0};
    dxw = {dx[SW-1], dx};
    dyw = {dy[SW-1], dy};
    err_n = err;
    cx_n  = cx;
    cy_n  = cy;
    // Both tests use the pre-update e2; err accumulates both corrections.
    if (e2 >= dyw) begin
      err_n = err_n + dy;
      cx_n  = cx + sx;
    end
    if (e2 <= dxw) begin
      err_n = err_n + dx;
      cy_n  = cy + sy;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cx  <= '0;
      cy  <= '0;
      ex  <= '0;
      ey  <= '0;
      dx  <= '0;
      dy  <= '0;
      err <= '0;
      sx  <= '0;
      sy  <= '0;
    end else if (load) begin
      cx  <= scoord_t'({2'b00, x0});
      cy  <= scoord_t'({2'b00, y0});
      ex  <= scoord_t'({2'b00, x1});
      ey  <= scoord_t'({2'b00, y1});
      dx  <= adx;
      dy  <= -ady;
      err <= adx - ady;
      sx  <= ddx[SW-1] ? '1 : ((ddx == '0) ? '0 : scoord_t'(1));
      sy  <= ddy[SW-1] ? '1 : ((ddy == '0) ? '0 : scoord_t'(1));
    end else if (step) begin
      cx  <= cx_n;
      cy  <= cy_n;
      err <= err_n;
    end
  end

  assign x    = cx[COORD_W-1:0];
  assign y    = cy[COORD_W-1:0];
  assign last = (cx == ex) && (cy == ey);

endmodule

// File: rtl/touch_stroke_writer.sv
// Turns pen samples into single-pixel video-RAM writes: Bresenham segments
// between consecutive pen-down samples, plus a full-panel clear sweep.
module touch_stroke_writer
  import tft_pkg::*;
#(
  parameter int unsigned         X_RES    = TFT_X_RES,
  parameter int unsigned         Y_RES    = TFT_Y_RES,
  parameter int unsigned         COORD_W  = TFT_COORD_W,
  parameter int unsigned         COLOR_W  = TFT_COLOR_W,
  parameter logic [COLOR_W-1:0]  BG_COLOR = '0
) (
  input  logic               cclk,
  input  logic               rst,
  input  logic               sample_valid,
  output logic               sample_ready,
  input  logic [COORD_W-1:0] sample_x,
  input  logic [COORD_W-1:0] sample_y,
  input  logic               sample_down,
  input  logic [COLOR_W-1:0] pen_color,
  input  logic               clear_req,
  output logic               busy,
  output logic               wr_ena,
  output logic [COORD_W-1:0] wr_x,
  output logic [COORD_W-1:0] wr_y,
  output logic [COLOR_W-1:0] wr_data,
  output logic               clear_done
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(X_RES - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(Y_RES - 1);

  state_t             state;
  logic               prev_valid, clear_pend;
  logic [COORD_W-1:0] prev_x, prev_y, cx, cy, px, py;
  logic [COLOR_W-1:0] color;
  logic               accept, load, step, last;

  assign accept = sample_valid & sample_ready;
  assign load   = accept & sample_down;
  assign step   = ((state == SETUP) || (state == DRAW)) && !last;

  tft_line_stepper #(.COORD_W(COORD_W)) u_stepper (
    .clk  (cclk),
    .rst  (rst),
    .load (load),
    .x0   (prev_valid ? prev_x : sample_x),
    .y0   (prev_valid ? prev_y : sample_y),
    .x1   (sample_x),
    .y1   (sample_y),
    .step (step),
    .x    (px),
    .y    (py),
    .last (last)
  );

  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sample_ready <= 1'b0;
      busy         <= 1'b0;
      wr_ena       <= 1'b0;
      wr_x         <= '0;
      wr_y         <= '0;
      wr_data      <= '0;
      clear_done   <= 1'b0;
      prev_valid   <= 1'b0;
      clear_pend   <= 1'b0;
      prev_x       <= '0;
      prev_y       <= '0;
      cx           <= '0;
      cy           <= '0;
      color        <= '0;
    end else begin
      clear_pend <= clear_pend | clear_req;
      clear_done <= 1'b0;
      wr_ena     <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_pend) begin
            state        <= CLEAR;
            cx           <= '0;
            cy           <= '0;
            busy         <= 1'b1;
            sample_ready <= 1'b0;
          end else if (accept && sample_down) begin
            color        <= pen_color;
            state        <= SETUP;
            busy         <= 1'b1;
            sample_ready <= 1'b0;
          end else begin
            if (accept) prev_valid <= 1'b0;
            sample_ready <= !clear_req;
          end
        end
        // The start point is already loaded at accept, so the first write is
        // registered while leaving SETUP; DRAW emits the remaining points.
        SETUP, DRAW: begin
          wr_ena  <= in_bounds(32'(px), 32'(py), X_RES, Y_RES);
          wr_x    <= px;
          wr_y    <= py;
          wr_data <= color;
          if (last) begin
            prev_x       <= px;
            prev_y       <= py;
            prev_valid   <= 1'b1;
            state        <= IDLE;
            busy         <= 1'b0;
            sample_ready <= !(clear_pend | clear_req);
          end else begin
            state <= DRAW;
          end
        end
        CLEAR: begin
          wr_ena  <= 1'b1;
          wr_x    <= cx;
          wr_y    <= cy;
          wr_data <= BG_COLOR;
          if (cx == X_LAST) begin
            cx <= '0;
            if (cy == Y_LAST) begin
              state      <= DONE;
              clear_pend <= 1'b0;
              prev_valid <= 1'b0;
            end else begin
              cy <= cy + COORD_W'(1);
            end
          end else begin
            cx <= cx + COORD_W'(1);
          end
        end
        DONE: begin
          clear_done   <= 1'b1;
          state        <= IDLE;
          busy         <= 1'b0;
          sample_ready <= !clear_req;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_touch_stroke_writer.sv
// Directed bench for touch_stroke_writer: table of stroke samples with
// hand-computed write runs, plus clear-sweep and reset-mid-segment sequences.
module tb_touch_stroke_writer;

  // Fewer lines than the real panel keeps the clear sweep short; x keeps 480.
  localparam int unsigned TB_X_RES = 480;
  localparam int unsigned TB_Y_RES = 32;

  logic        cclk = 1'b0;
  logic        rst, sample_valid, sample_down, clear_req;
  logic [11:0] sample_x, sample_y;
  logic [8:0]  pen_color;
  logic        sample_ready, busy, wr_ena, clear_done;
  logic [11:0] wr_x, wr_y;
  logic [8:0]  wr_data;

  int checks = 0;
  int failures = 0;

  int cap_n, cap_lat, cap_busy, cap_data;
  int cap_x[64];
  int cap_y[64];

  always #5 cclk = ~cclk;

  touch_stroke_writer #(.X_RES(TB_X_RES), .Y_RES(TB_Y_RES)) dut (
    .cclk         (cclk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_x     (sample_x),
    .sample_y     (sample_y),
    .sample_down  (sample_down),
    .pen_color    (pen_color),
    .clear_req    (clear_req),
    .busy         (busy),
    .wr_ena       (wr_ena),
    .wr_x         (wr_x),
    .wr_y         (wr_y),
    .wr_data      (wr_data),
    .clear_done   (clear_done)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge cclk);
    #1;
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (!sample_ready && t < 100) begin
      tick();
      t++;
    end
    chk("ready_before_sample", int'(sample_ready), 1);
  endtask

  // Offers one sample, then records every write until sample_ready returns.
  task automatic do_sample(input int x, input int y, input logic down, input int col);
    int cyc;
    wait_ready();
    sample_x     = 12'(x);
    sample_y     = 12'(y);
    sample_down  = down;
    pen_color    = 9'(col);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    cap_n = 0; cap_lat = 0; cap_busy = 0; cap_data = -1;
    cyc = 1;
    while (cyc < 600) begin
      if (busy) cap_busy++;
      if (wr_ena) begin
        if (cap_n < 64) begin
          cap_x[cap_n] = int'(wr_x);
          cap_y[cap_n] = int'(wr_y);
        end
        if (cap_n == 0) begin
          cap_lat  = cyc;
          cap_data = int'(wr_data);
        end
        cap_n++;
      end
      if (sample_ready) break;
      tick();
      cyc++;
    end
    chk("sample_finish", int'(sample_ready), 1);
  endtask

  typedef struct {
    int   x, y;
    logic down;
    int   col;
    int   n, fx, fy, lx, ly, busyc;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int seg_n, clr_n, order_err, done_n, ready_hi, other, ecx, ecy, first_clr, last_clr, done_wr, post_wr;
    int ex7[7];
    int ey7[7];

    vecs[0]  = '{100, 20, 1'b1, 'h1C0, 1, 100, 20, 100, 20, 1};
    vecs[1]  = '{  0,  0, 1'b0, 0,     0,   0,  0,   0,  0, 0};
    vecs[2]  = '{ 10,  5, 1'b1, 'h007, 1,  10,  5,  10,  5, 1};
    vecs[3]  = '{ 14,  5, 1'b1, 'h007, 5,  10,  5,  14,  5, 5};
    vecs[4]  = '{ 10,  5, 1'b1, 'h038, 5,  14,  5,  10,  5, 5};
    vecs[5]  = '{  0,  0, 1'b0, 0,     0,   0,  0,   0,  0, 0};
    vecs[6]  = '{  0,  0, 1'b1, 'h1FF, 1,   0,  0,   0,  0, 1};
    vecs[7]  = '{  2,  6, 1'b1, 'h1FF, 7,   0,  0,   2,  6, 7};
    vecs[8]  = '{  0,  0, 1'b0, 0,     0,   0,  0,   0,  0, 0};
    vecs[9]  = '{ 50, 25, 1'b1, 'h0AA, 1,  50, 25,  50, 25, 1};
    vecs[10] = '{  0,  0, 1'b0, 0,     0,   0,  0,   0,  0, 0};
    vecs[11] = '{470, 10, 1'b1, 'h1C0, 1, 470, 10, 470, 10, 1};
    vecs[12] = '{490, 10, 1'b1, 'h1C0, 10, 470, 10, 479, 10, 21};
    vecs[13] = '{  0,  0, 1'b0, 0,     0,   0,  0,   0,  0, 0};
    vecs[14] = '{  5, 30, 1'b1, 'h049, 1,   5, 30,   5, 30, 1};
    vecs[15] = '{  5, 34, 1'b1, 'h049, 2,   5, 30,   5, 31, 5};
    ex7 = '{0, 0, 1, 1, 1, 2, 2};
    ey7 = '{0, 1, 2, 3, 4, 5, 6};

    rst = 1'b1; sample_valid = 1'b0; sample_down = 1'b0; clear_req = 1'b0;
    sample_x = '0; sample_y = '0; pen_color = '0;
    repeat (3) tick();
    chk("rst_wr_ena", int'(wr_ena), 0);
    chk("rst_wr_xy", int'({wr_x, wr_y}), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(sample_ready), 0);
    chk("rst_clear_done", int'(clear_done), 0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", int'(sample_ready), 1);

    for (int i = 0; i < 16; i++) begin
      do_sample(vecs[i].x, vecs[i].y, vecs[i].down, vecs[i].col);
      chk($sformatf("v%0d_count", i), cap_n, vecs[i].n);
      chk($sformatf("v%0d_busy", i), cap_busy, vecs[i].busyc);
      if (vecs[i].n > 0 && cap_n > 0 && cap_n <= 64) begin
        chk($sformatf("v%0d_first", i), cap_x[0] * 1000 + cap_y[0], vecs[i].fx * 1000 + vecs[i].fy);
        chk($sformatf("v%0d_last", i), cap_x[cap_n-1] * 1000 + cap_y[cap_n-1],
            vecs[i].lx * 1000 + vecs[i].ly);
        chk($sformatf("v%0d_data", i), cap_data, vecs[i].col);
        chk($sformatf("v%0d_latency", i), cap_lat, 2);
      end
    end

    // Exact Bresenham point sequence for a steep segment.
    do_sample(0, 0, 1'b0, 0);
    do_sample(0, 0, 1'b1, 'h155);
    do_sample(2, 6, 1'b1, 'h155);
    chk("steep_count", cap_n, 7);
    for (int k = 0; k < 7; k++)
      if (k < cap_n) chk($sformatf("steep_pt%0d", k), cap_x[k] * 1000 + cap_y[k], ex7[k] * 1000 + ey7[k]);

    // Clear request mid-segment: segment finishes, then one raster sweep.
    do_sample(0, 0, 1'b0, 0);
    do_sample(20, 30, 1'b1, 'h1C0);
    wait_ready();
    sample_x = 12'd24; sample_y = 12'd30; sample_down = 1'b1; pen_color = 9'h1C0;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    seg_n = 0; clr_n = 0; order_err = 0; done_n = 0; ready_hi = 0; other = 0;
    ecx = 0; ecy = 0; first_clr = -1; last_clr = -1; done_wr = 0;
    for (int c = 0; c < 40000; c++) begin
      if (wr_ena) begin
        if (wr_data == 9'h1C0 && clr_n == 0) begin
          seg_n++;
        end else if (wr_data == 9'h000) begin
          if (int'(wr_x) != ecx || int'(wr_y) != ecy) order_err++;
          if (clr_n == 0) first_clr = int'(wr_x) * 1000 + int'(wr_y);
          last_clr = int'(wr_x) * 1000 + int'(wr_y);
          clr_n++;
          ecx++;
          if (ecx == int'(TB_X_RES)) begin
            ecx = 0;
            ecy++;
          end
        end else begin
          other++;
        end
      end
      if (clear_done) begin
        done_n++;
        if (wr_ena) done_wr++;
      end
      if (sample_ready && done_n == 0) ready_hi++;
      if (done_n > 0 && !clear_done) break;
      clear_req = (c == 1000);
      tick();
    end
    clear_req = 1'b0;
    chk("clr_seg_writes", seg_n, 5);
    chk("clr_writes", clr_n, int'(TB_X_RES * TB_Y_RES));
    chk("clr_order_err", order_err, 0);
    chk("clr_first", first_clr, 0);
    chk("clr_last", last_clr, int'((TB_X_RES - 1) * 1000 + TB_Y_RES - 1));
    chk("clr_other_writes", other, 0);
    chk("clr_done_pulses", done_n, 1);
    chk("clr_done_wr_ena", done_wr, 0);
    chk("clr_ready_during", ready_hi, 0);
    post_wr = 0;
    for (int c = 0; c < 40; c++) begin
      if (wr_ena) post_wr++;
      tick();
    end
    chk("clr_no_second_sweep", post_wr, 0);
    chk("clr_ready_after", int'(sample_ready), 1);

    // Clear dropped prev_valid: next pen-down is a lone point.
    do_sample(200, 15, 1'b1, 'h0F0);
    chk("post_clr_single", cap_n, 1);

    // Asynchronous reset in the middle of a segment.
    do_sample(0, 0, 1'b0, 0);
    do_sample(0, 0, 1'b1, 'h111);
    wait_ready();
    sample_x = 12'd40; sample_y = 12'd0; sample_down = 1'b1; pen_color = 9'h111;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    repeat (5) tick();
    chk("mid_draw_busy", int'(busy), 1);
    chk("mid_draw_wr_ena", int'(wr_ena), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_wr_ena", int'(wr_ena), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_clear_done", int'(clear_done), 0);
    chk("arst_ready", int'(sample_ready), 0);
    chk("arst_wr_x", int'(wr_x), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("arst_ready_after", int'(sample_ready), 1);
    do_sample(60, 20, 1'b1, 'h0F0);
    chk("arst_single_count", cap_n, 1);
    if (cap_n > 0) chk("arst_single_pt", cap_x[0] * 1000 + cap_y[0], 60020);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
